dma_rd_stream: RTL

- Downstream consumer of the 2-D address generator's output stream (addr/first/last/valid/ready).
- Issues one read per accepted address to a single-port SRAM with fixed 1-cycle read latency.
- Returns the read data as a valid/ready stream with first/last carried alongside.
- A small credit-controlled output FIFO absorbs SRAM latency and downstream backpressure without dropping data.

---
 rtl/dma_pkg.sv | 14 +
 rtl/dma_sync_fifo.sv | 87 ++++++++
 rtl/dma_sync_fifo_chk.sv | 11 +
 rtl/dma_rd_stream.sv | 113 +++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared constants and types for the DMA read-side blocks.
// The flag bundle travels with both the address stream and the data stream.
package dma_pkg;

    localparam int DMA_AW     = 11;
    localparam int DMA_DW     = 32;
    localparam int DMA_FLAG_W = 2;

    typedef struct packed {
        logic first;
        logic last;
    } dma_flags_t;

endpackage

// File: rtl/dma_sync_fifo.sv
// Parameterised register FIFO: circular buffer with wrap-around pointers and an
// occupancy count. The head entry is presented combinationally on rdata.
module dma_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == {CW{1'b0}});
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rdata     = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next-state for storage, pointers and count.
    always_comb begin
        mem_d = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; storage is cleared so outputs read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dma_sync_fifo_chk.sv
// Protocol checker for dma_sync_fifo: the producer must never push into a full FIFO.
module dma_sync_fifo_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic full
);

    push_when_full_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/dma_rd_stream.sv
// Turns an address stream into SRAM reads and returns the data as a valid/ready
// stream with first/last attached; credits cover the in-flight read plus FIFO space.
module dma_rd_stream
    import dma_pkg::*;
#(
    parameter int AW    = DMA_AW,
    parameter int DW    = DMA_DW,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] s_addr,
    input  logic          s_first,
    input  logic          s_last,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          mem_cs,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] m_data,
    output logic          m_first,
    output logic          m_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = DW + DMA_FLAG_W;

    logic          inflight_q, inflight_d;
    dma_flags_t    tag_q, tag_d;

    logic          accept_s;
    logic          pop_s;
    logic          s_ready_s;
    logic [CW:0]   used_s;
    logic [CW:0]   net_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_cnt_s;
    logic [FW-1:0] fifo_wdata_s;
    logic [FW-1:0] fifo_rdata_s;
    dma_flags_t    head_flags_s;

    // Credit check: a beat popped this cycle frees a slot for the address accepted now.
    always_comb begin
        used_s    = {1'b0, fifo_cnt_s} + {{CW{1'b0}}, inflight_q};
        net_s     = used_s - {{CW{1'b0}}, pop_s};
        s_ready_s = (net_s < (CW+1)'(DEPTH));
    end

    assign pop_s    = ~fifo_empty_s & m_ready;
    assign accept_s = s_valid & s_ready_s;

    // The in-flight flag marks that mem_rdata carries a beat this cycle.
    always_comb begin
        inflight_d = accept_s;
        if (accept_s) begin
            tag_d.first = s_first;
            tag_d.last  = s_last;
        end else begin
            tag_d = tag_q;
        end
    end

    // Read-tracking registers; reset drops any read still returning from the SRAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            tag_q      <= {DMA_FLAG_W{1'b0}};
        end else begin
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    assign fifo_wdata_s = {tag_q, mem_rdata};

    dma_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .wdata (fifo_wdata_s),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_cnt_s)
    );

    dma_sync_fifo_chk u_fifo_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .full  (fifo_full_s)
    );

    assign head_flags_s = fifo_rdata_s[FW-1:DW];

    assign s_ready  = s_ready_s;
    assign mem_cs   = accept_s;
    assign mem_addr = s_addr;
    assign m_data   = fifo_rdata_s[DW-1:0];
    assign m_first  = head_flags_s.first;
    assign m_last   = head_flags_s.last;
    assign m_valid  = ~fifo_empty_s;
    assign busy     = inflight_q | (fifo_cnt_s != {CW{1'b0}});

endmodule
